ro_freq_counter: RTL and testbench

- Measures the frequency of a free-running ring-oscillator output against the system clock.
- Sits at the consumer end of the on-chip ring oscillator: it counts rising edges of the asynchronous oscillator signal inside a fixed gate window of clk cycles.
- Reports the count with a one-cycle valid strobe for readout on dedicated outputs.
- Supports single-shot and continuous (back-to-back window) modes.

---
 rtl/ro_freq_counter.sv | 129 ++++++++++++
 tb/tb_ro_freq_counter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized rising edges of osc_in
// over a fixed window of GATE_CYCLES clk cycles, single-shot or back-to-back.
module ro_freq_counter #(
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int TW = $clog2(GATE_CYCLES);
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [TW-1:0]    TIMER_LOAD  = TW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 delayed_q;
  logic                 osc_edge;
  logic [SW-1:0]        settle_cnt;
  logic [TW-1:0]        timer;
  logic [CNT_W-1:0]     acc;
  logic [CNT_W-1:0]     acc_nxt;
  logic                 sat;
  logic                 sat_nxt;

  // Synchronizer chain plus one delay flop; osc_edge is a one-cycle rise pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      delayed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], osc_in};
      delayed_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign osc_edge = sync_q[SYNC_STAGES-1] & ~delayed_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == '0) state_nxt = MEASURE;
      MEASURE: if (timer == '0) state_nxt = DONE;
      DONE:    state_nxt = continuous ? MEASURE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating accumulate; sat records an edge arriving while already at max.
  always_comb begin
    acc_nxt = acc;
    sat_nxt = sat;
    if (state == MEASURE && osc_edge) begin
      if (acc == CNT_MAX) sat_nxt = 1'b1;
      else                acc_nxt = acc + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt  <= '0;
      timer       <= '0;
      acc         <= '0;
      sat         <= 1'b0;
      count       <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc        <= '0;
            sat        <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) timer <= TIMER_LOAD;
          else                  settle_cnt <= settle_cnt - SW'(1);
        end
        MEASURE: begin
          acc <= acc_nxt;
          sat <= sat_nxt;
          // The final-cycle edge is folded in via acc_nxt so it is counted.
          if (timer == '0) begin
            count       <= acc_nxt;
            overflow    <= sat_nxt;
            count_valid <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DONE: begin
          if (continuous) begin
            acc   <= '0;
            sat   <= 1'b0;
            timer <= TIMER_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter: two instances (short gate, and narrow
// counter for saturation) with a scoreboard of expected strobe cycle/count/overflow.
module tb_ro_freq_counter;

  localparam int W = 41;  // {strobe cycle[31:0], count[7:0], overflow}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       osc = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       cont_a = 1'b0;
  logic       cont_b = 1'b0;
  logic [7:0] count_a;
  logic [3:0] count_b;
  logic       cv_a, cv_b, ovf_a, ovf_b, busy_a, busy_b;
  logic [1:0] st_a, st_b;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         osc_mode = 0;  // 0: static low, 1: static high, 2: period-4 toggle
  int         tog_cnt = 0;
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];

  ro_freq_counter #(.GATE_CYCLES(16), .CNT_W(8), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start_a), .continuous(cont_a),
    .count(count_a), .count_valid(cv_a), .overflow(ovf_a), .busy(busy_a),
    .dbg_state(st_a)
  );

  ro_freq_counter #(.GATE_CYCLES(64), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start_b), .continuous(cont_b),
    .count(count_b), .count_valid(cv_b), .overflow(ovf_b), .busy(busy_b),
    .dbg_state(st_b)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator stimulus changes on the falling edge, toggling every 2 clk.
  always @(negedge clk) begin
    if (osc_mode == 2) begin
      tog_cnt = tog_cnt + 1;
      if (tog_cnt == 2) begin
        osc = ~osc;
        tog_cnt = 0;
      end
    end else begin
      osc = (osc_mode == 1);
      tog_cnt = 0;
    end
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endfunction

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!rst && cv_a) begin
      if (exp_a.size() == 0) begin
        check("unexpected_strobe_a", 32'(count_a), 32'hFFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_a.pop_front();
        check("strobe_cycle_a", 32'(cyc), e[40:9]);
        check("count_a", 32'(count_a), 32'(e[8:1]));
        check("overflow_a", 32'(ovf_a), 32'(e[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cv_b) begin
      if (exp_b.size() == 0) begin
        check("unexpected_strobe_b", 32'(count_b), 32'hFFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_b.pop_front();
        check("strobe_cycle_b", 32'(cyc), e[40:9]);
        check("count_b", 32'(count_b), 32'(e[8:1]));
        check("overflow_b", 32'(ovf_b), 32'(e[0]));
      end
    end
  end

  // Driver tasks; all are entered and left on a falling edge.
  task automatic push_a(input int at, input logic [7:0] cnt, input logic ovf);
    exp_a.push_back({32'(at), cnt, ovf});
  endtask

  task automatic pulse_start_a(input bit expect_it, input logic [7:0] cnt,
                               input logic ovf);
    // start is sampled on the next rising edge (cyc+1); strobe 19 edges later.
    if (expect_it) push_a(cyc + 20, cnt, ovf);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b(input logic [7:0] cnt, input logic ovf);
    exp_b.push_back({32'(cyc + 68), cnt, ovf});
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_a.size() == 0 && exp_b.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_count_a", 32'(count_a), 0);
    check("reset_valid_a", 32'(cv_a), 0);
    check("reset_overflow_a", 32'(ovf_a), 0);
    check("reset_busy_a", 32'(busy_a), 0);
    check("reset_busy_b", 32'(busy_b), 0);

    // Single-shot, period-4 input
    osc_mode = 2;
    repeat (5) @(negedge clk);
    n = cyc;
    check("idle_busy_a", 32'(busy_a), 0);
    pulse_start_a(1, 8'd4, 1'b0);
    check("busy_after_start_a", 32'(busy_a), 1);
    wait_until(n + 20);
    check("busy_in_done_a", 32'(busy_a), 1);
    @(negedge clk);
    check("busy_after_done_a", 32'(busy_a), 0);
    wait_drain(50);

    // Static low, then static high
    osc_mode = 0;
    repeat (8) @(negedge clk);
    pulse_start_a(1, 8'd0, 1'b0);
    wait_drain(50);
    osc_mode = 1;
    repeat (8) @(negedge clk);
    pulse_start_a(1, 8'd0, 1'b0);
    wait_drain(50);

    // Saturation on the 4-bit instance, then a static run clears overflow
    osc_mode = 2;
    repeat (5) @(negedge clk);
    pulse_start_b(8'd15, 1'b1);
    wait_drain(120);
    osc_mode = 0;
    repeat (8) @(negedge clk);
    pulse_start_b(8'd0, 1'b0);
    wait_drain(120);
    check("busy_end_b", 32'(busy_b), 0);

    // Continuous mode: windows every 17 cycles, drop continuous in the 4th
    osc_mode = 2;
    repeat (5) @(negedge clk);
    cont_a = 1'b1;
    n = cyc;
    pulse_start_a(1, 8'd4, 1'b0);
    push_a(n + 37, 8'd4, 1'b0);
    push_a(n + 54, 8'd4, 1'b0);
    push_a(n + 71, 8'd4, 1'b0);
    wait_until(n + 60);
    cont_a = 1'b0;
    wait_until(n + 72);
    check("busy_after_cont_a", 32'(busy_a), 0);
    wait_drain(50);

    // Reset during the 10th MEASURE cycle aborts the window
    n = cyc;
    pulse_start_a(0, 8'd0, 1'b0);
    wait_until(n + 13);
    check("busy_mid_window_a", 32'(busy_a), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy_a", 32'(busy_a), 0);
    check("abort_count_a", 32'(count_a), 0);
    check("abort_overflow_a", 32'(ovf_a), 0);
    repeat (30) @(negedge clk);
    pulse_start_a(1, 8'd4, 1'b0);
    wait_drain(50);

    // start pulses in SETTLE, MEASURE and DONE are ignored
    n = cyc;
    pulse_start_a(1, 8'd4, 1'b0);
    wait_until(n + 2);
    pulse_start_a(0, 8'd0, 1'b0);
    wait_until(n + 10);
    pulse_start_a(0, 8'd0, 1'b0);
    wait_until(n + 20);
    pulse_start_a(0, 8'd0, 1'b0);
    check("idle_after_done_start_a", 32'(busy_a), 0);
    repeat (40) @(negedge clk);
    check("still_idle_a", 32'(st_a), 0);

    check("drain_a", 32'(exp_a.size()), 0);
    check("drain_b", 32'(exp_b.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
